// File: rtl/iecdrv_gcr_stream.sv
// Drive-side GCR bitstream engine between a per-track byte buffer and the
// drive logic disk port. Serialises buffer bytes into a bit stream with SYNC
// detection and byte framing in read mode, and commits dout into the buffer
// at byte boundaries in write mode. Supports one or two heads.
module iecdrv_gcr_stream #(
    parameter int SIDES    = 1,   // 1 or 2 heads; 2 adds side as buf_addr MSB
    parameter int LEN_W    = 13,  // width of track byte position
    parameter int DIV_MAX  = 16,  // bit cell = DIV_MAX - freq ce ticks
    parameter int BR_TICKS = 2    // ce ticks byte_n is held low
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     mtr,
    input  logic [1:0]               freq,
    input  logic                     mode,
    input  logic                     side,
    input  logic                     wps_n,
    input  logic [7:0]               dout,
    output logic [7:0]               din,
    output logic                     sync_n,
    output logic                     byte_n,
    input  logic [LEN_W-1:0]         track_len,
    output logic [LEN_W+SIDES-2:0]   buf_addr,
    input  logic [7:0]               buf_rd_data,
    output logic [7:0]               buf_wr_data,
    output logic                     buf_we
);

    localparam int TW = $clog2(DIV_MAX + 1);
    localparam int BW = (BR_TICKS > 1) ? $clog2(BR_TICKS) : 1;
    localparam logic [BW-1:0] BR_LOAD = BW'(BR_TICKS - 1);

    logic [TW-1:0]    timer;
    logic [1:0]       freq_q;
    logic [TW-1:0]    cell_last;
    logic             bit_tick;
    logic             boundary;

    logic [2:0]       tx_cnt;
    logic [7:0]       tx_sr;
    logic [LEN_W-1:0] pos;
    logic [LEN_W-1:0] pos_next;
    logic             adv;       // pos advances one clk after the boundary
    logic [1:0]       ld_pipe;   // waits out the buffer read latency

    logic [6:0]       rx_sr;
    logic [2:0]       rx_cnt;
    logic [3:0]       ones_cnt;
    logic [3:0]       ones_next;
    logic             rx_bit;
    logic [BW-1:0]    br_cnt;

    // The zone is latched at each cell restart so a mid-cell freq change
    // only affects the following cell.
    assign cell_last = TW'(DIV_MAX - 1) - TW'(freq_q);
    assign bit_tick  = ce && mtr && (timer == cell_last);
    assign boundary  = bit_tick && (tx_cnt == 3'd7);
    assign rx_bit    = tx_sr[7];

    generate
        if (SIDES == 2) begin : g_two_sides
            assign buf_addr = {side, pos};
        end else begin : g_one_side
            // side has no meaning with a single head
            assign buf_addr = pos | {LEN_W{side & 1'b0}};
        end
    endgenerate

    // Next track position with wrap at track_len-1; short tracks pin to 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pos_next = pos + 1'b1;
        if (track_len <= LEN_W'(1) || pos >= track_len - 1'b1) begin
            pos_next = '0;
        end
    end

    // Saturating run length of consecutive one bits.
    always_comb begin
        ones_next = '0;
        if (rx_bit) begin
            ones_next = (ones_cnt == 4'd15) ? 4'd15 : ones_cnt + 4'd1;
        end
    end

    // Bit-cell timer, frozen while the motor is off.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            timer  <= '0;
            freq_q <= freq;
        end else if (ce && mtr) begin
            if (bit_tick) begin
                timer  <= '0;
                freq_q <= freq;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Transmit side: byte framing, track position and shift register reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt  <= '0;
            tx_sr   <= '0;
            pos     <= '0;
            adv     <= 1'b0;
            ld_pipe <= 2'b01;
        end else begin
            ld_pipe <= {ld_pipe[0], 1'b0};
            adv     <= boundary;
            if (adv) begin
                pos     <= pos_next;
                ld_pipe <= 2'b01;
            end
            if (bit_tick) begin
                tx_cnt <= tx_cnt + 3'd1;
            end
            if (ld_pipe[1]) begin
                tx_sr <= buf_rd_data;
            end else if (bit_tick) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    // Receive framing, SYNC detection, byte-ready strobe and buffer writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sr       <= '0;
            rx_cnt      <= '0;
            ones_cnt    <= '0;
            sync_n      <= 1'b1;
            din         <= 8'hFF;
            byte_n      <= 1'b1;
            br_cnt      <= '0;
            buf_we      <= 1'b0;
            buf_wr_data <= 8'h00;
        end else begin
            buf_we <= 1'b0;

            if (!mtr) begin
                byte_n <= 1'b1;
            end else if (!byte_n && ce) begin
                if (br_cnt == '0) begin
                    byte_n <= 1'b1;
                end else begin
                    br_cnt <= br_cnt - 1'b1;
                end
            end

            if (!mode) begin
                // Write mode: any partial rx byte is dropped and SYNC cleared.
                sync_n   <= 1'b1;
                ones_cnt <= '0;
                rx_cnt   <= '0;
                if (boundary) begin
                    byte_n <= 1'b0;
                    br_cnt <= BR_LOAD;
                    if (wps_n) begin
                        buf_we      <= 1'b1;
                        buf_wr_data <= dout;
                    end
                end
            end else if (bit_tick) begin
                rx_sr    <= {rx_sr[5:0], rx_bit};
                ones_cnt <= ones_next;
                if (rx_bit && ones_next >= 4'd10) begin
                    sync_n <= 1'b0;
                    rx_cnt <= '0;
                end else if (!rx_bit && !sync_n) begin
                    // The zero that ends SYNC is bit 0 of the next byte.
                    sync_n <= 1'b1;
                    rx_cnt <= 3'd1;
                end else if (rx_cnt == 3'd7) begin
                    din    <= {rx_sr, rx_bit};
                    rx_cnt <= '0;
                    byte_n <= 1'b0;
                    br_cnt <= BR_LOAD;
                end else begin
                    rx_cnt <= rx_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iecdrv_gcr_stream.sv
// Directed bench for iecdrv_gcr_stream: zone timing, reset, SYNC framing,
// position wrap, write strobes and the two-sided address path.
module tb_iecdrv_gcr_stream;

    logic        clk = 1'b0;
    logic        reset, ce, mtr, mode, side, wps_n;
    logic [1:0]  freq;
    logic [7:0]  dout;
    logic [12:0] track_len;

    logic [7:0]  din1, din2, wr1, wr2, rd1, rd2;
    logic        sync_n1, sync_n2, byte_n1, byte_n2, we1, we2;
    logic [12:0] addr1;
    logic [13:0] addr2;

    logic [7:0]  mem [16];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int r_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered buffer read: data valid one clk after the address.
    always @(posedge clk) begin
        rd1 <= mem[addr1[3:0]];
        rd2 <= mem[addr2[3:0]];
    end

    iecdrv_gcr_stream #(.SIDES(1), .LEN_W(13), .DIV_MAX(16), .BR_TICKS(2)) u_dut1 (
        .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .freq(freq), .mode(mode),
        .side(side), .wps_n(wps_n), .dout(dout), .din(din1), .sync_n(sync_n1),
        .byte_n(byte_n1), .track_len(track_len), .buf_addr(addr1),
        .buf_rd_data(rd1), .buf_wr_data(wr1), .buf_we(we1)
    );

    iecdrv_gcr_stream #(.SIDES(2), .LEN_W(13), .DIV_MAX(16), .BR_TICKS(2)) u_dut2 (
        .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .freq(freq), .mode(mode),
        .side(side), .wps_n(wps_n), .dout(dout), .din(din2), .sync_n(sync_n2),
        .byte_n(byte_n2), .track_len(track_len), .buf_addr(addr2),
        .buf_rd_data(rd2), .buf_wr_data(wr2), .buf_we(we2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        r_cyc = cyc;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    function automatic logic [13:0] cur_addr(input int which);
        return (which == 2) ? addr2 : {1'b0, addr1};
    endfunction

    task automatic wait_addr_change(input int which, input string tag);
        logic [13:0] last;
        bit seen;
        last = cur_addr(which);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cur_addr(which) != last) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, " timeout"}, 0, 1);
    endtask

    task automatic wait_fall1(input string tag, input int budget, output int at);
        logic prev;
        prev = byte_n1;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (prev && !byte_n1) begin
                at = cyc;
                break;
            end
            prev = byte_n1;
        end
        if (at < 0) check({tag, " timeout"}, 0, 1);
    endtask

    task automatic wait_we1(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (we1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, " timeout"}, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, low;
        int sfall, srise, sync_pulses, post_pulses, post_at;
        logic [7:0] post_din;
        logic prev_b, prev_s;
        logic [1:0] exp_wrap [5];
        int bad_b, bad_a, we_cnt, falls;

        reset = 1'b1; ce = 1'b1; mtr = 1'b1; freq = 2'd3; mode = 1'b1;
        side = 1'b0; wps_n = 1'b1; dout = 8'h00; track_len = 13'd16;
        fill(8'h55);

        // Reset state and zone 3 timing: 13-clk cells, 104-clk bytes.
        do_reset();
        check("rst din", din1, 8'hFF);
        check("rst sync_n", sync_n1, 1);
        check("rst byte_n", byte_n1, 1);
        check("rst buf_we", we1, 0);
        check("rst buf_wr_data", wr1, 8'h00);
        check("rst buf_addr", addr1, 0);

        wait_fall1("zone first", 300, t1);
        check("zone first fall", t1 - r_cyc, 104);
        check("zone din", din1, 8'h55);
        low = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (byte_n1) break;
            low++;
        end
        check("zone low width", low, 2);
        wait_fall1("zone second", 300, t2);
        check("zone period", t2 - t1, 104);

        // Reset while byte_n is low mid-read.
        reset = 1'b1;
        tick();
        check("midrst byte_n", byte_n1, 1);
        check("midrst din", din1, 8'hFF);
        check("midrst sync_n", sync_n1, 1);
        check("midrst buf_we", we1, 0);
        check("midrst buf_addr", addr1, 0);
        tick();
        tick();
        reset = 1'b0;

        // SYNC framing: FF FF 52 at freq 0 (16-clk cells).
        freq = 2'd0;
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h52;
        do_reset();
        sfall = -1; srise = -1; sync_pulses = 0; post_pulses = 0; post_at = -1;
        post_din = 8'h00;
        prev_b = byte_n1; prev_s = sync_n1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (prev_s && !sync_n1) sfall = cyc - r_cyc;
            if (!prev_s && sync_n1) srise = cyc - r_cyc;
            if (prev_b && !byte_n1) begin
                if (!sync_n1) begin
                    sync_pulses++;
                end else if (srise >= 0) begin
                    post_pulses++;
                    if (post_at < 0) begin
                        post_at = cyc - r_cyc;
                        post_din = din1;
                    end
                end
            end
            prev_b = byte_n1;
            prev_s = sync_n1;
        end
        check("sync fall time", sfall, 160);
        check("sync rise time", srise, 272);
        check("sync pulses during sync", sync_pulses, 0);
        check("sync pulses after", post_pulses, 1);
        check("sync byte time", post_at, 384);
        check("sync byte din", post_din, 8'h52);

        // Position wrap with track_len 4, then a one-byte track.
        fill(8'h55);
        freq = 2'd3;
        track_len = 13'd4;
        do_reset();
        check("wrap start", addr1, 0);
        exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3;
        exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd1;
        for (int k = 0; k < 5; k++) begin
            wait_addr_change(1, "wrap");
            check($sformatf("wrap addr %0d", k), addr1, {11'd0, exp_wrap[k]});
        end
        track_len = 13'd1;
        repeat (300) tick();
        check("len1 addr", addr1, 0);

        // Write mode, unprotected then protected.
        track_len = 13'd4;
        mode = 1'b0;
        dout = 8'hA5;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_we1("write we");
            check($sformatf("write addr %0d", k), addr1, k % 4);
            check($sformatf("write data %0d", k), wr1, 8'hA5);
            check($sformatf("write byte_n %0d", k), byte_n1, 0);
            tick();
            check($sformatf("write we width %0d", k), we1, 0);
        end
        check("write sync_n", sync_n1, 1);
        check("write din hold", din1, 8'hFF);
        wps_n = 1'b0;
        we_cnt = 0;
        falls = 0;
        prev_b = byte_n1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (we1) we_cnt++;
            if (prev_b && !byte_n1) falls++;
            prev_b = byte_n1;
        end
        check("protect we", we_cnt, 0);
        check("protect byte_n pulses", falls, 2);

        // Two-sided addressing and motor stop.
        mode = 1'b1;
        wps_n = 1'b1;
        track_len = 13'd16;
        side = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) wait_addr_change(2, "side");
        check("side1 addr", addr2, 14'h2003);
        side = 1'b0;
        #1;
        check("side0 addr", addr2, 14'h0003);
        side = 1'b1;
        repeat (40) tick();
        mtr = 1'b0;
        bad_b = 0;
        bad_a = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!byte_n2) bad_b++;
            if (addr2 != 14'h2003) bad_a++;
        end
        check("mtr off byte_n", bad_b, 0);
        check("mtr off addr", bad_a, 0);
        mtr = 1'b1;
        wait_addr_change(2, "mtr on");
        check("mtr on addr", addr2, 14'h2004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
